// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: drives an external 4-bit ALU through an IDLE/EXEC/RESP handshake.
// Optional accumulator feedback for operand A when ALU_CMD_DRIVER_ACC_EN is defined.
module alu_cmd_driver #(
  parameter int OVF_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_func,
  input  logic [3:0]           cmd_a,
  input  logic [3:0]           cmd_b,
  input  logic                 cmd_use_acc,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_func,
  input  logic [3:0]           alu_out,
  input  logic                 alu_cout,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_data,
  output logic                 rsp_cout,
  output logic                 rsp_overflow,
  output logic                 rsp_true,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic [3:0]           acc_value
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next;
  logic [3:0] a_sel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = cmd_valid ? EXEC : IDLE;
      EXEC:    next = RESP;
      RESP:    next = rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
  end
`ifdef ALU_CMD_DRIVER_ACC_EN
  logic [3:0] acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (state == EXEC) acc <= alu_out;
  assign acc_value = acc;
  assign a_sel = cmd_use_acc ? acc : cmd_a;
`else
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
  assign acc_value = 4'b0000;
  assign a_sel = cmd_a;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_func     <= '0;
      rsp_data     <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_true     <= 1'b0;
      ovf_count    <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        alu_a    <= a_sel;
        alu_b    <= cmd_b;
        alu_func <= cmd_func;
      end
      if (state == EXEC) begin
        rsp_data     <= alu_out;
        rsp_cout     <= alu_cout;
        rsp_overflow <= alu_overflow;
        rsp_true     <= alu_func[2:1] == 2'b11 && alu_out == 4'hf;
        if (alu_overflow && ovf_count != '1) ovf_count <= ovf_count + OVF_CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed scoreboard bench for alu_cmd_driver with a behavioural ALU.
// Accumulator expectations follow ALU_CMD_DRIVER_ACC_EN.
module tb_alu_cmd_driver;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_use_acc = 0;
  logic [2:0] cmd_func = 0, alu_func;
  logic [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_out, rsp_data, acc_value;
  logic alu_cout, alu_overflow, rsp_valid, rsp_ready = 1, rsp_cout, rsp_overflow, rsp_true;
  logic [3:0] ovf_count;
  int errors = 0, checks = 0;
  typedef struct {logic [3:0] d; logic c, o, t;} rsp_t;
  rsp_t sb[$];
  logic [3:0] tb_acc = 0, exp_ovf = 0;

  alu_cmd_driver #(.OVF_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
    .alu_cout(alu_cout), .alu_overflow(alu_overflow), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .rsp_overflow(rsp_overflow), .rsp_true(rsp_true), .ovf_count(ovf_count),
    .acc_value(acc_value));

  always #5 clk = ~clk;

  // returns {cout, out[3:0], overflow}
  function automatic logic [5:0] alu_f(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    case (f)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; return {s, a[3] == b[3] && s[3] != a[3]}; end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; return {s, a[3] != b[3] && s[3] != a[3]}; end
      3'd2: return {1'b0, ~a, 1'b0};
      3'd3: return {1'b0, a & b, 1'b0};
      3'd4: return {1'b0, a | b, 1'b0};
      3'd5: return {1'b0, a ^ b, 1'b0};
      3'd6: return {1'b0, ($signed(a) < $signed(b)) ? 4'hf : 4'h0, 1'b0};
      default: return {1'b0, (a == b) ? 4'hf : 4'h0, 1'b0};
    endcase
  endfunction

  always_comb {alu_cout, alu_out, alu_overflow} = alu_f(alu_func, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a negedge in IDLE; hold = cycles rsp_ready stays low in RESP.
  task automatic txn(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b,
                     input logic use_acc, input int hold);
    logic [5:0] r;
    logic [3:0] a_eff;
    rsp_t e, g;
`ifdef ALU_CMD_DRIVER_ACC_EN
    a_eff = use_acc ? tb_acc : a;
`else
    a_eff = a;
`endif
    r = alu_f(f, a_eff, b);
    e.d = r[4:1]; e.c = r[5]; e.o = r[0]; e.t = f[2:1] == 2'b11 && r[4:1] == 4'hf;
    sb.push_back(e);
    if (r[0] && exp_ovf != 4'hf) exp_ovf++;
`ifdef ALU_CMD_DRIVER_ACC_EN
    tb_acc = r[4:1];
`endif
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_func = f; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_valid = 1;
    rsp_ready = hold == 0;
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk);
    check("alu_a", alu_a, a_eff);
    check("alu_b", alu_b, b);
    check("alu_func", alu_func, f);
    check("exec_no_valid", rsp_valid, 0);
    check("exec_no_ready", cmd_ready, 0);
    @(negedge clk);
    check("latency_valid", rsp_valid, 1);
    g = sb.pop_front();
    check("rsp_data", rsp_data, g.d);
    check("rsp_cout", rsp_cout, g.c);
    check("rsp_ovf", rsp_overflow, g.o);
    check("rsp_true", rsp_true, g.t);
    check("ovf_count", ovf_count, exp_ovf);
    check("acc_value", acc_value, tb_acc);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1; cmd_a = ~a; cmd_b = ~b; cmd_func = ~f;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, g.d);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 0; rsp_ready = 1;
    @(negedge clk);
    check("post_valid", rsp_valid, 0);
    check("post_ready", cmd_ready, 1);
    check("post_data_held", rsp_data, g.d);
    check("post_alu_a_held", alu_a, a_eff);
    check("post_func_held", alu_func, f);
  endtask

  initial begin
    #2;
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_flags", {rsp_cout, rsp_overflow, rsp_true}, 0);
    check("rst_alu", {alu_func, alu_a, alu_b}, 0);
    check("rst_ovf", ovf_count, 0);
    check("rst_acc", acc_value, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    txn(3'd0, 4'b0111, 4'b0001, 0, 0);
    check("add_ovf_data", rsp_data, 4'b1000);
    check("add_ovf_flag", rsp_overflow, 1);
    check("add_ovf_cout", rsp_cout, 0);
    check("add_ovf_count", ovf_count, 1);
    txn(3'd6, 4'b1110, 4'b0001, 0, 0);
    check("less_data", {rsp_true, rsp_data}, 5'b11111);
    txn(3'd7, 4'b0101, 4'b0101, 0, 0);
    check("equal_data", {rsp_true, rsp_data}, 5'b11111);
    txn(3'd7, 4'b0101, 4'b0100, 0, 0);
    check("equal_false", {rsp_true, rsp_data}, 5'b00000);
    txn(3'd1, 4'b0011, 4'b0101, 0, 0);
    txn(3'd0, 4'b1111, 4'b0001, 0, 0);
    check("add_carry", {rsp_cout, rsp_overflow, rsp_data}, 6'b100000);
    for (int i = 0; i < 8; i++) txn(3'(i), 4'($urandom), 4'($urandom), 0, 0);
    txn(3'd5, 4'b1010, 4'b0110, 0, 5);
    check("hold_xor", rsp_data, 4'b1100);

    for (int i = 0; i < 20; i++) txn(3'd0, 4'b0111, 4'b0001, 0, 0);
    check("ovf_saturate", ovf_count, 15);

    txn(3'd0, 4'b0011, 4'b0001, 0, 0);
    txn(3'd0, 4'b1001, 4'b0010, 1, 0);
`ifdef ALU_CMD_DRIVER_ACC_EN
    check("acc_alu_a", alu_a, 4'b0100);
    check("acc_rsp", rsp_data, 4'b0110);
    check("acc_value", acc_value, 4'b0110);
`else
    check("noacc_alu_a", alu_a, 4'b1001);
    check("noacc_rsp", rsp_data, 4'b1011);
    check("noacc_value", acc_value, 4'b0000);
`endif

    cmd_func = 3'd0; cmd_a = 4'b0111; cmd_b = 4'b0001; cmd_valid = 1; rsp_ready = 0;
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk); @(negedge clk);
    check("pre_rst_valid", rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_ovf", ovf_count, 0);
    check("async_rst_data", rsp_data, 0);
    check("async_rst_acc", acc_value, 0);
    @(negedge clk);
    rsp_ready = 1; rst_n = 1;
    tb_acc = 0; exp_ovf = 0;
    @(negedge clk);
    check("rst_release_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    txn(3'd4, 4'b1000, 4'b0001, 0, 0);
    check("post_rst_or", rsp_data, 4'b1001);
    check("post_rst_ovf", ovf_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
